// File: rtl/dac_counter.sv
// DAC sample counter: free-running WIDTH-bit count
// while at_max is high, cleared when it drops.
module dac_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             at_max,
  output logic [WIDTH-1:0] dacCount
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_nxt;

  // Advance while enabled (carry out dropped), clear otherwise
  always_comb begin
    count_nxt = '0;
    if (at_max) count_nxt = count + WIDTH'(1);
  end

  // Count register; reset forces zero without waiting for clk
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) count <= '0;
    else       count <= count_nxt;
  end

  assign dacCount = count;

endmodule

// File: tb/tb_dac_counter.sv
// Self-checking bench for dac_counter: vector table,
// reset/wrap sequences and randomized model compare.
module tb_dac_counter;

  logic       tb_clk;
  logic       nRst;
  logic       at_max;
  logic [7:0] dacCount;

  int errors;
  int checks;
  int model;

  typedef struct {
    bit en;
    int edges;
    int exp;
  } vec_t;

  dac_counter #(.WIDTH(8)) dut (
    .clk      (tb_clk),
    .nRst     (nRst),
    .at_max   (at_max),
    .dacCount (dacCount)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  task automatic check(input string name, input int act,
                       input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  initial begin
    vec_t vecs[9];
    errors = 0;
    checks = 0;
    nRst   = 1'b0;
    at_max = 1'b0;

    // power-on reset
    #2;
    check("por_2ns", int'(dacCount), 0);
    repeat (3) begin
      @(negedge tb_clk);
      check("por_hold", int'(dacCount), 0);
    end
    nRst = 1'b1;
    @(negedge tb_clk);
    check("rel_idle", int'(dacCount), 0);

    // cumulative vectors: enable, edges held, expected count
    vecs[0] = '{1'b1, 25,  25};
    vecs[1] = '{1'b0, 1,   0};
    vecs[2] = '{1'b0, 3,   0};
    vecs[3] = '{1'b1, 300, 44};
    vecs[4] = '{1'b0, 1,   0};
    vecs[5] = '{1'b1, 255, 255};
    vecs[6] = '{1'b1, 1,   0};
    vecs[7] = '{1'b1, 2,   2};
    vecs[8] = '{1'b0, 1,   0};
    foreach (vecs[i]) begin
      at_max = vecs[i].en;
      repeat (vecs[i].edges) @(posedge tb_clk);
      @(negedge tb_clk);
      check($sformatf("vec%0d", i), int'(dacCount),
            vecs[i].exp);
    end

    // async reset mid-count
    at_max = 1'b1;
    repeat (12) @(posedge tb_clk);
    @(negedge tb_clk);
    check("pre_rst", int'(dacCount), 12);
    #2 nRst = 1'b0;
    #1 check("async_rst", int'(dacCount), 0);
    @(posedge tb_clk);
    #1 check("rst_held", int'(dacCount), 0);
    @(negedge tb_clk);
    nRst = 1'b1;
    @(negedge tb_clk);
    check("rst_resume", int'(dacCount), 1);

    // per-edge increment over 512 edges
    model = 1;
    for (int k = 0; k < 512; k++) begin
      @(negedge tb_clk);
      model = (model + 1) % 256;
      check("mono", int'(dacCount), model);
    end

    // randomized enable with occasional reset pulses
    for (int k = 0; k < 600; k++) begin
      at_max = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) begin
        #2 nRst = 1'b0;
        #1 check("rnd_rst", int'(dacCount), 0);
        #1 nRst = 1'b1;
        model = 0;
      end
      @(posedge tb_clk);
      model = at_max ? (model + 1) % 256 : 0;
      @(negedge tb_clk);
      check("rnd", int'(dacCount), model);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/dac_counter.md
# dac_counter

Free-running 8-bit sample counter that drives the DAC code path in the audio/tone output chain. While the upstream rate/enable signal `at_max` is asserted, it advances by one on every clock edge and wraps modulo 256. When `at_max` is deasserted, it returns to zero on the next clock edge. The output is a plain registered count consumed by the DAC waveform logic.

## Interface
Parameters:
- `WIDTH`, default 8: counter width in bits. All requirements below use 8. The general rule is wrap at 2^WIDTH−1.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `nRst`  input  1  reset, asynchronous and active-low; forces the counter to 0 immediately.
- `at_max`  input  1  count enable. 1 = increment; 0 = synchronous clear to 0.
- `dacCount`  output  WIDTH (8)  current count, driven directly from the register with no combinational path from inputs.

## Operation
- Single WIDTH-bit register `count`, with `dacCount = count`.
- Priority, highest first:
  1. `nRst == 0`: `count <= 0` asynchronously. This holds for as long as reset is low, regardless of `clk` and `at_max`.
  2. Rising `clk` with `at_max == 1`: `count <= count + 1`, modulo 2^WIDTH. 255 → 0 wraps silently, with no flag and no saturation.
  3. Rising `clk` with `at_max == 0`: `count <= 0`.
- No other state, no FSM, no handshake. `at_max` is sampled only at rising edges.
- Unsigned arithmetic only. The carry out of the MSB is discarded.

## Timing
- Reset value: `dacCount = 0`. It is visible within the same delta/timestep that `nRst` falls, not waiting for a clock.
- Reset release: leaving `nRst` high with `at_max == 0` keeps `dacCount = 0` indefinitely. Releasing reset between edges causes no glitch.
- Latency: one cycle from `at_max` sampled high to the first increment. After N consecutive rising edges with `at_max == 1`, starting from 0, `dacCount == N mod 256`.
- Clear latency: one cycle. The first rising edge that samples `at_max == 0` makes `dacCount = 0`.
- Wrap: the edge after 255 (with `at_max == 1`) yields 0, and counting continues at 1, 2, …
- Reset mid-count: an asynchronous assertion at any count value forces 0 at once. On release, counting resumes from 0 at the first qualified edge.
- Output changes only on a rising `clk` or a falling `nRst`. It is stable across the low phase, so a bench may sample at negedge.

## Test plan
- Power-on reset: `nRst = 0`, `at_max = 0`; check at 2 ns and over the following cycles → `dacCount == 0`. Release `nRst` at a negedge → still 0 at the next negedge.
- Count: after reset, set `at_max = 1` just after a posedge and hold for 25 rising edges → `dacCount == 25` at the following negedge.
- Clear: from count 25, drop `at_max` for one rising edge → `dacCount == 0` at the next negedge, then stays 0 while `at_max == 0`.
- Wrap: hold `at_max = 1` for 300 rising edges from 0 → values pass 255 → 0 and the count equals 300 mod 256 = 44. Then drop `at_max` → 0 after one edge.
- Async reset mid-count: at count ≥ 10, pull `nRst` low mid-cycle with `at_max = 1` → `dacCount == 0` before the next posedge. Release reset → first qualified edge gives 1.
- Per-edge monotonic check: with `at_max = 1`, each posedge satisfies `dacCount_new == (dacCount_old + 1) mod 256` for at least 512 edges.
